// File: rtl/wb_arch_state_pkg.sv
// Shared pipeline defines (word/address widths, enable encodings) used by MEM/WB, ID and write-back.
// Also holds the LLbit next-state rule so every stage agrees on flush priority.
package wb_arch_state_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [WORD_W-1:0]     ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    // Flush outranks a same-cycle LL/SC update: the link must not survive an exception.
    function automatic logic llbit_next(input logic flush, input logic we,
                                        input logic value, input logic cur);
        if (flush) begin
            return 1'b0;
        end
        if (we == WRITE_DISABLE) begin
            return cur;
        end
        return value;
    endfunction

endpackage

// File: rtl/wb_arch_state_if.sv
// Write-back bundle in, GPR read ports to ID, committed HI/LO/LLbit out to EX/MEM.
// master = pipeline side driving the bundle and read addresses; slave = wb_arch_state.
interface wb_arch_state_if #(
    parameter int DATA_W = wb_arch_state_pkg::WORD_W,
    parameter int ADDR_W = wb_arch_state_pkg::REG_ADDR_W
);
    logic              flush;
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_whilo;
    logic              wb_LLbit_we;
    logic              wb_LLbit_value;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              LLbit_o;

    modport master (
        output flush, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, LLbit_o
    );

    modport slave (
        input  flush, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o, LLbit_o
    );

endinterface

// File: rtl/wb_arch_state_gpr_file.sv
// 32-entry GPR file: r0 hard-wired to zero, two combinational read ports with write-through bypass.
// Write commits on the clock edge; reads are 0-cycle, no backpressure.
module wb_arch_state_gpr_file
    import wb_arch_state_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= DATA_W'(ZERO_WORD);
            end
        end else if (we_i == WRITE_ENABLE && waddr_i != ADDR_W'(NOP_REG_ADDR)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass lets ID see a result retiring this very cycle without a stall.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              r_rst,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (r_rst == RST_ENABLE || raddr == ADDR_W'(NOP_REG_ADDR) || re == READ_DISABLE) begin
            return DATA_W'(ZERO_WORD);
        end
        if (re == READ_ENABLE && we == WRITE_ENABLE && waddr == raddr) begin
            return wdata;
        end
        return stored;
    endfunction

    always_comb begin
        rdata1_o = read_port(rst, re1_i, raddr1_i, we_i, waddr_i, wdata_i, regs_q[raddr1_i]);
        rdata2_o = read_port(rst, re2_i, raddr2_i, we_i, waddr_i, wdata_i, regs_q[raddr2_i]);
    end

endmodule

// File: rtl/wb_arch_state.sv
// Write-back architectural state: GPR file, HI/LO pair and LLbit committed from the MEM/WB bundle.
// HI/LO/LLbit visible one edge after write, GPR reads bypassed; accepts a bundle every cycle, never stalls.
module wb_arch_state
    import wb_arch_state_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input logic            clk,
    input logic            rst,
    wb_arch_state_if.slave wb
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              llbit_q, llbit_d;

    wb_arch_state_gpr_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb.wb_wreg),
        .waddr_i  (wb.wb_wd),
        .wdata_i  (wb.wb_wdata),
        .re1_i    (wb.re1),
        .raddr1_i (wb.raddr1),
        .rdata1_o (wb.rdata1),
        .re2_i    (wb.re2),
        .raddr2_i (wb.raddr2),
        .rdata2_o (wb.rdata2)
    );

    // Flush leaves HI/LO alone: the bundle here belongs to an already-retired instruction.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wb.wb_whilo == WRITE_ENABLE) begin
            hi_d = wb.wb_hi;
            lo_d = wb.wb_lo;
        end
        llbit_d = llbit_next(wb.flush, wb.wb_LLbit_we, wb.wb_LLbit_value, llbit_q);
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q    <= DATA_W'(ZERO_WORD);
            lo_q    <= DATA_W'(ZERO_WORD);
            llbit_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            llbit_q <= llbit_d;
        end
    end

    assign wb.hi_o    = hi_q;
    assign wb.lo_o    = lo_q;
    assign wb.LLbit_o = llbit_q;

endmodule

// File: tb/tb_wb_arch_state.sv
// Self-checking bench for wb_arch_state: per-cycle vector table plus a model-driven GPR sweep.
module tb_wb_arch_state;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_arch_state_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_arch_state #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        ell;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t        vec_sb[$];
    logic [31:0] dat_sb[$];

    function automatic vec_t v(
        input logic r, input logic fl, input logic wr, input logic [4:0] wd,
        input logic [31:0] wdat, input logic whl, input logic [31:0] hi, input logic [31:0] lo,
        input logic lwe, input logic lval, input logic r1, input logic [4:0] a1,
        input logic r2, input logic [4:0] a2, input logic [31:0] e1, input logic [31:0] e2,
        input logic [31:0] ehi, input logic [31:0] elo, input logic ell
    );
        vec_t t;
        t.rst = r;    t.flush = fl; t.wreg = wr;  t.wd = wd;    t.wdata = wdat;
        t.whilo = whl; t.hi = hi;   t.lo = lo;    t.llwe = lwe; t.llval = lval;
        t.re1 = r1;   t.ra1 = a1;   t.re2 = r2;   t.ra2 = a2;
        t.e1 = e1;    t.e2 = e2;    t.ehi = ehi;  t.elo = elo;  t.ell = ell;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        rst                = t.rst;
        bus.flush          = t.flush;
        bus.wb_wreg        = t.wreg;
        bus.wb_wd          = t.wd;
        bus.wb_wdata       = t.wdata;
        bus.wb_whilo       = t.whilo;
        bus.wb_hi          = t.hi;
        bus.wb_lo          = t.lo;
        bus.wb_LLbit_we    = t.llwe;
        bus.wb_LLbit_value = t.llval;
        bus.re1            = t.re1;
        bus.raddr1         = t.ra1;
        bus.re2            = t.re2;
        bus.raddr2         = t.ra2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    localparam int NV = 22;
    localparam logic [31:0] A = 32'hAAAA_0000;
    localparam logic [31:0] B = 32'h0000_BBBB;

    initial begin
        vec_t        tbl [NV];
        vec_t        got;
        logic [31:0] model [32];
        logic [31:0] w;

        tbl[0]  = v(1,0,1,5,32'hDEAD_BEEF,0,0,0,0,0, 1,5,1,5, 0,0,0,0,0);
        tbl[1]  = v(0,0,0,0,0,0,0,0,0,0,            1,5,0,0, 0,0,0,0,0);
        tbl[2]  = v(0,0,1,7,32'h1234_5678,0,0,0,0,0, 1,7,0,7, 32'h1234_5678,0,0,0,0);
        tbl[3]  = v(0,0,0,0,0,0,0,0,0,0,            1,7,0,7, 32'h1234_5678,0,0,0,0);
        tbl[4]  = v(0,0,1,0,32'hFFFF_FFFF,0,0,0,0,0, 1,0,1,7, 0,32'h1234_5678,0,0,0);
        tbl[5]  = v(0,0,0,0,0,0,0,0,0,0,            1,0,1,0, 0,0,0,0,0);
        tbl[6]  = v(0,0,0,0,0,1,A,B,0,0,            0,0,0,0, 0,0,0,0,0);
        tbl[7]  = v(0,0,0,0,0,0,32'h1111_1111,32'h2222_2222,0,0, 0,0,0,0, 0,0,A,B,0);
        tbl[8]  = v(0,0,0,0,0,0,0,0,0,0,            0,0,0,0, 0,0,A,B,0);
        tbl[9]  = v(0,0,0,0,0,0,0,0,1,1,            0,0,0,0, 0,0,A,B,0);
        tbl[10] = v(0,0,0,0,0,0,0,0,0,0,            0,0,0,0, 0,0,A,B,1);
        tbl[11] = v(0,1,1,3,32'h55,0,0,0,1,1,       1,3,0,0, 32'h55,0,A,B,1);
        tbl[12] = v(0,0,0,0,0,0,0,0,0,0,            1,3,0,0, 32'h55,0,A,B,0);
        tbl[13] = v(0,0,0,0,0,0,0,0,1,1,            0,0,0,0, 0,0,A,B,0);
        tbl[14] = v(0,0,0,0,0,0,0,0,0,0,            0,0,0,0, 0,0,A,B,1);
        tbl[15] = v(0,0,0,0,0,0,0,0,1,0,            0,0,0,0, 0,0,A,B,1);
        tbl[16] = v(0,0,0,0,0,0,0,0,0,0,            0,0,0,0, 0,0,A,B,0);
        tbl[17] = v(0,0,1,9,32'h9,0,0,0,0,0,        1,9,1,9, 32'h9,32'h9,A,B,0);
        tbl[18] = v(0,0,0,0,0,0,0,0,0,0,            1,9,1,7, 32'h9,32'h1234_5678,A,B,0);
        tbl[19] = v(0,0,1,10,32'hA0A0_A0A0,0,0,0,0,0, 1,9,1,10, 32'h9,32'hA0A0_A0A0,A,B,0);
        tbl[20] = v(1,0,1,9,32'hFFFF_0000,1,1,2,1,1, 1,9,1,3, 0,0,A,B,0);
        tbl[21] = v(0,0,0,0,0,0,0,0,0,0,            1,9,1,7, 0,0,0,0,0);

        // First reset edge with a live write bundle; tbl[0] is the second reset cycle.
        apply(tbl[0]);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            vec_sb.push_back(tbl[i]);
            #1;
            got = vec_sb.pop_front();
            check($sformatf("vec%0d.rdata1", i), bus.rdata1, got.e1);
            check($sformatf("vec%0d.rdata2", i), bus.rdata2, got.e2);
            check($sformatf("vec%0d.hi_o", i),   bus.hi_o,   got.ehi);
            check($sformatf("vec%0d.lo_o", i),   bus.lo_o,   got.elo);
            check($sformatf("vec%0d.LLbit_o", i), {31'b0, bus.LLbit_o}, {31'b0, got.ell});
        end

        // State is freshly reset here: sweep every register through the model.
        for (int k = 0; k < 32; k++) model[k] = 32'h0;

        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            w = $urandom;
            apply(v(0,0,1,5'(k),w,0,0,0,0,0, 1,5'(k),1,5'(k-1), 0,0,0,0,0));
            dat_sb.push_back(w);
            dat_sb.push_back(model[k-1]);
            #1;
            check($sformatf("sweep_wr%0d.rdata1", k), bus.rdata1, dat_sb.pop_front());
            check($sformatf("sweep_wr%0d.rdata2", k), bus.rdata2, dat_sb.pop_front());
            model[k] = w;
        end

        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            apply(v(0,0,0,0,0,0,0,0,0,0, 1,5'(k),1,5'(31-k), 0,0,0,0,0));
            dat_sb.push_back(model[k]);
            dat_sb.push_back(model[31-k]);
            #1;
            check($sformatf("sweep_rd%0d.rdata1", k), bus.rdata1, dat_sb.pop_front());
            check($sformatf("sweep_rd%0d.rdata2", k), bus.rdata2, dat_sb.pop_front());
        end

        check("sweep.hi_o", bus.hi_o, 32'h0);
        check("sweep.lo_o", bus.lo_o, 32'h0);
        check("sweep.LLbit_o", {31'b0, bus.LLbit_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
